// File: rtl/shift_reg_pkg.sv
// Shared mode encodings for the universal shift register.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/universal_shift_register.sv
// WIDTH-bit hold/shift/load register with serial ports and a word-completion counter.
// Define Q_BAR_EN to add the complementary output q_bar.
module universal_shift_register
  import shift_reg_pkg::*;
#(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  parameter int                 CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
`ifdef Q_BAR_EN
  ,
  output logic [WIDTH-1:0] q_bar
`endif
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] shr_val, shl_val;
  logic             cnt_last;

  // A one-bit register has no neighbours, so a shift simply takes the serial bit.
  generate
    if (WIDTH == 1) begin : g_narrow
      assign shr_val = ser_in_r;
      assign shl_val = ser_in_l;
    end else begin : g_wide
      assign shr_val = {ser_in_r, q_q[WIDTH-1:1]};
      assign shl_val = {q_q[WIDTH-2:0], ser_in_l};
    end
  endgenerate

  assign cnt_last = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr) begin
      q_d   = RESET_VALUE;
      cnt_d = '0;
    end else if (en) begin
      case (mode_e'(mode))
        MODE_SHR, MODE_SHL: begin
          q_d    = (mode_e'(mode) == MODE_SHR) ? shr_val : shl_val;
          // Wrap and pulse on the same edge so word_done lines up with the full word in q.
          cnt_d  = cnt_last ? '0 : cnt_q + 1'b1;
          done_d = cnt_last;
        end
        MODE_LOAD: begin
          q_d   = d;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= RESET_VALUE;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q         = q_q;
  assign shift_cnt = cnt_q;
  assign word_done = done_q;
  assign ser_out_r = q_q[0];
  assign ser_out_l = q_q[WIDTH-1];

`ifdef Q_BAR_EN
  assign q_bar = ~q_q;
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench: driver pushes model predictions, monitor pops and compares after each edge.
module tb_universal_shift_register;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0, en = 1'b0, ser_in_r = 1'b0, ser_in_l = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] d = '0;
  logic [W-1:0] q;
  logic         ser_out_r, ser_out_l, word_done;
  logic [3:0]   shift_cnt;
`ifdef Q_BAR_EN
  logic [W-1:0] q_bar;
`endif

  universal_shift_register #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .mode(mode),
    .ser_in_r(ser_in_r), .ser_in_l(ser_in_l), .d(d), .q(q),
    .ser_out_r(ser_out_r), .ser_out_l(ser_out_l),
    .shift_cnt(shift_cnt), .word_done(word_done)
`ifdef Q_BAR_EN
    , .q_bar(q_bar)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned q;
    int unsigned cnt;
    bit          done;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned m_q = 0, m_cnt = 0;
  bit          m_done = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: the register as an integer, the counter as shifts modulo W.
  task automatic model_step(input bit c, input bit e, input int m, input bit sr, input bit sl,
                            input int unsigned dv);
    m_done = 0;
    if (c) begin
      m_q = 0; m_cnt = 0;
    end else if (e) begin
      if (m == 1 || m == 2) begin
        if (m == 1) m_q = (m_q >> 1) | (int'(sr) << (W - 1));
        else        m_q = ((m_q << 1) | int'(sl)) % (1 << W);
        m_cnt  = (m_cnt + 1) % W;
        m_done = (m_cnt == 0);
      end else if (m == 3) begin
        m_q = dv; m_cnt = 0;
      end
    end
  endtask

  task automatic drive(input bit c, input bit e, input int m, input bit sr, input bit sl,
                       input int unsigned dv);
    exp_t x;
    @(negedge clk);
    clr = c; en = e; mode = m[1:0]; ser_in_r = sr; ser_in_l = sl; d = dv[W-1:0];
    model_step(c, e, m, sr, sl, dv);
    x.q = m_q; x.cnt = m_cnt; x.done = m_done;
    sb.push_back(x);
  endtask

  task automatic check_reset_now();
    check("rst_q", q, 0);
    check("rst_cnt", shift_cnt, 0);
    check("rst_done", word_done, 0);
`ifdef Q_BAR_EN
    check("rst_q_bar", q_bar, 8'hFF);
`endif
  endtask

  // Asserts reset between edges with no prediction pending, checks outputs before any edge.
  task automatic async_reset();
    @(negedge clk);
    clr = 0; en = 1; mode = 2'b11; d = 8'h3C;
    #2 rst_n = 1'b0;
    #1 check_reset_now();
    m_q = 0; m_cnt = 0; m_done = 0;
    @(negedge clk);
    check_reset_now();
    rst_n = 1'b1;
    en = 0;
  endtask

  // Monitor: each edge that has a prediction queued gets compared.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      check("q", q, x.q);
      check("shift_cnt", shift_cnt, x.cnt);
      check("word_done", word_done, x.done);
      check("ser_out_r", ser_out_r, x.q & 1);
      check("ser_out_l", ser_out_l, (x.q >> (W - 1)) & 1);
`ifdef Q_BAR_EN
      check("q_bar", q_bar, (~x.q) & 8'hFF);
`endif
      $display("edge q=%02h cnt=%0d done=%0b exp q=%02h cnt=%0d done=%0b",
               q, shift_cnt, word_done, x.q, x.cnt, x.done);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned r;
    #1 check_reset_now();
    @(negedge clk);
    rst_n = 1'b1;

    drive(0, 1, 3, 0, 0, 8'hA5);
    async_reset();

    drive(0, 1, 3, 0, 0, 8'hA5);
    repeat (3) drive(0, 0, 1, 1, 1, 8'h00);

    drive(1, 0, 0, 0, 0, 8'h00);
    repeat (8) drive(0, 1, 1, 1, 0, 8'h00);
    drive(0, 1, 0, 0, 0, 8'h00);

    drive(0, 1, 3, 0, 0, 8'h01);
    @(posedge clk); #2 check("ser_out_r_before_shl", ser_out_r, 1);
    repeat (8) drive(0, 1, 2, 0, 0, 8'h00);

    drive(1, 1, 3, 0, 0, 8'hFF);
    repeat (5) drive(0, 1, 1, 1, 0, 8'h00);
    drive(0, 1, 3, 0, 0, 8'h5A);
    repeat (8) drive(0, 1, 2, 0, 1, 8'h00);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      drive(r < 4, r < 90, $urandom_range(0, 3) | ((r < 60) ? 1 : 0),
            1'($urandom), 1'($urandom), $urandom_range(0, 255));
      if (i == 150) begin
        repeat (2) @(negedge clk);
        async_reset();
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
